period_meter: RTL and testbench
===============================

Name: period_meter

Overview:
- Measurement counterpart to the team's clock dividers: samples an asynchronous square wave (e.g. a divided clock looped back through a Pmod pin) on the 100 MHz system clock.
- Reports period and high time in system-clock cycles, so the waveform generator's divider outputs are checked in hardware.
- Output feeds the seven-segment/LED readout logic.

Parameters:
- WIDTH, 28, width of counters and result outputs.
- TIMEOUT, 28'd100000000, cycles without a rising edge before declaring the input stopped. Must be ≤ 2^WIDTH-1 and ≥ 4.

Ports:
- clock_in  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- sig_in  input  1  asynchronous square wave to measure.
- period_out  output  WIDTH  last measured period in clock_in cycles.
- high_out  output  WIDTH  last measured high time in clock_in cycles.
- valid  output  1  one-cycle pulse when period_out/high_out update.
- timeout  output  1  level; input stopped, no valid measurement.
- measuring  output  1  high while the state machine is in MEASURE.

Behaviour:
- Reset values (reset_n low, asynchronous): synchronizer flops 0, edge register 0, cnt 0, hcnt 0, state IDLE, all outputs 0.
- Synchronizer: sig_in passes through 2 flops to give sig_s; a third flop gives sig_d.
- Edge detect: rise = sig_s & ~sig_d. A pin edge is detected 3 cycles after it occurs. All counting uses sig_s.
- IDLE state:
  - cnt and hcnt hold 0.
  - On rise: go to MEASURE, cnt<=1, hcnt<=1, no valid pulse.
- MEASURE, on a rise cycle:
  - period_out<=cnt, high_out<=hcnt, valid<=1, timeout<=0.
  - Then cnt<=1, hcnt<=1; stay in MEASURE.
- MEASURE, on a non-rise cycle:
  - cnt<=cnt+1.
  - hcnt<=hcnt+1 when sig_s=1, else hcnt holds.
- Result for a clean input with period N cycles and high time H cycles: period_out=N, high_out=H.
  - Exact, no ±1 offset.
  - Latency from the 2nd pin rising edge to the valid pulse is 4 cycles.
- Timeout: in MEASURE, when cnt==TIMEOUT and there is no rise on that cycle:
  - state<=IDLE, timeout<=1, period_out<=0, high_out<=0, cnt<=0, hcnt<=0.
  - No valid pulse.
  - The next measurement needs two further rises.
- Simultaneous timeout and rise on the same cycle: the rise wins; the measurement is reported with period_out=TIMEOUT and valid=1.
- cnt never exceeds TIMEOUT, so there is no wrap-around. hcnt ≤ cnt always.
- valid is high for exactly one cycle per update and is never asserted two cycles in a row.
- measuring = (state==MEASURE), registered.
- Input constraints: minimum measurable period is 2 cycles (high ≥1, low ≥1 after synchronization). Faster inputs alias; no error is flagged.
- sig_in already high at reset release: sig_s goes 0→1 and is taken as the first rise (IDLE→MEASURE). The first partial period is never reported.
- Reset mid-measurement: all state is cleared immediately, and operation restarts in IDLE once reset_n deasserts.
- Outputs hold their last values between updates.

Optional Feature:
- PERIOD_METER_DUTY_EN defined: hcnt logic is present and high_out reports the high time as above.
- PERIOD_METER_DUTY_EN undefined:
  - hcnt is not implemented.
  - high_out is tied to 0.
  - All other behaviour and timing are unchanged.
  - The port list is identical in both builds.

Test Plan:
- Clean square wave, period 10, high 4, TIMEOUT=1000: first valid follows the 2nd rise with period_out=10, high_out=4. valid then pulses every 10 cycles; timeout=0; measuring=1.
- Loopback from a divider with DIVISOR=100000 (duty 50%), TIMEOUT=200000: period_out=100000, high_out=50000, with a valid pulse every 100000 cycles.
- TIMEOUT=1000, input stops low after a rise: timeout=1 exactly 1000 cycles after the detected rise; period_out=0, high_out=0, measuring=0, no valid. Restarting at period 20 gives timeout=0 and period_out=20 after the 2nd rise.
- TIMEOUT=50, input period exactly 50: the rise coincides with cnt==50; required result is valid=1, period_out=50, timeout stays 0.
- reset_n pulsed low mid-period: all outputs go to 0 asynchronously. The first valid after release follows the 2nd subsequent rise with correct values.
- sig_in held high through reset release, then toggled at period 8, high 3: no valid on the first detected rise. Reports 8/3 (8/0 in a build without PERIOD_METER_DUTY_EN).

Source files
------------

// File: rtl/period_meter_if.sv
// Signal bundle for period_meter: the square wave under test in, measurements out.
// master = the meter itself, slave = the readout logic that drives sig_in and consumes results.
interface period_meter_if #(
  parameter int WIDTH = 28
);
  logic             sig_in;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] high_out;
  logic             valid;
  logic             timeout;
  logic             measuring;

  modport master (
    input  sig_in,
    output period_out, high_out, valid, timeout, measuring
  );

  modport slave (
    output sig_in,
    input  period_out, high_out, valid, timeout, measuring
  );
endinterface

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous square wave in clock_in cycles.
// Define PERIOD_METER_DUTY_EN to build the high-time counter; otherwise high_out is tied to 0.
module period_meter #(
  parameter int               WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = 28'd100000000
) (
  input  logic           clock_in,
  input  logic           reset_n,
  period_meter_if.master mif
);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_nxt;
  logic             sync_1, sig_s, sig_d;
  logic             rise;
  logic             at_limit;
  logic [WIDTH-1:0] cnt;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sig_s  <= 1'b0;
      sig_d  <= 1'b0;
    end else begin
      sync_1 <= mif.sig_in;
      sig_s  <= sync_1;
      sig_d  <= sig_s;
    end
  end

  assign rise     = sig_s & ~sig_d;
  assign at_limit = (cnt == TIMEOUT);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // A rise on the timeout cycle wins, so the stop condition requires !rise.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise)              state_nxt = MEASURE;
      MEASURE: if (!rise && at_limit) state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= WIDTH'(1);
    end else if (state == IDLE || at_limit) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      mif.period_out <= '0;
      mif.valid      <= 1'b0;
      mif.timeout    <= 1'b0;
    end else begin
      mif.valid <= 1'b0;
      if (state == MEASURE) begin
        if (rise) begin
          mif.period_out <= cnt;
          mif.valid      <= 1'b1;
          mif.timeout    <= 1'b0;
        end else if (at_limit) begin
          mif.period_out <= '0;
          mif.timeout    <= 1'b1;
        end
      end
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  logic [WIDTH-1:0] hcnt;

  // The rise cycle itself has sig_s high, so it counts as the first high cycle.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
    end else if (rise) begin
      hcnt <= WIDTH'(1);
    end else if (state == IDLE || at_limit) begin
      hcnt <= '0;
    end else if (sig_s) begin
      hcnt <= hcnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      mif.high_out <= '0;
    end else if (state == MEASURE) begin
      if (rise)          mif.high_out <= hcnt;
      else if (at_limit) mif.high_out <= '0;
    end
  end
`else
  assign mif.high_out = '0;
`endif

  assign mif.measuring = (state == MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: two instances (TIMEOUT 1000 and 50) driven with square waves.
module tb_period_meter;

`ifdef PERIOD_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_a_n, rst_b_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  period_meter_if #(.WIDTH(28)) ifa ();
  period_meter_if #(.WIDTH(28)) ifb ();

  period_meter #(.WIDTH(28), .TIMEOUT(28'd1000)) u_a (
    .clock_in (clk),
    .reset_n  (rst_a_n),
    .mif      (ifa)
  );

  period_meter #(.WIDTH(28), .TIMEOUT(28'd50)) u_b (
    .clock_in (clk),
    .reset_n  (rst_b_n),
    .mif      (ifb)
  );

  // Observed valid pulses, recorded on the falling edge.
  logic [27:0] pa_q[$], ha_q[$], pb_q[$];
  int          ta_q[$];
  logic [27:0] exp_q[$];
  bit          prev_va = 1'b0, dbl_a = 1'b0;
  int          last_rise_a = 0;

  always @(negedge clk) begin
    if (ifa.valid) begin
      pa_q.push_back(ifa.period_out);
      ha_q.push_back(ifa.high_out);
      ta_q.push_back(cyc);
      if (prev_va) dbl_a = 1'b1;
    end
    prev_va = ifa.valid;
    if (ifb.valid) pb_q.push_back(ifb.period_out);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got cyc=%0d required finish", cyc);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs;
    pa_q.delete(); ha_q.delete(); ta_q.delete(); pb_q.delete(); exp_q.delete();
    dbl_a = 1'b0;
  endtask

  task automatic wave_a(input int period, input int high, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < period; c++) begin
        if (c == 0) last_rise_a = cyc;
        ifa.sig_in = (c < high);
        tick;
      end
  endtask

  task automatic wave_b(input int period, input int high, input int n);
    for (int p = 0; p < n; p++)
      for (int c = 0; c < period; c++) begin
        ifb.sig_in = (c < high);
        tick;
      end
  endtask

  task automatic reset_a;
    ifa.sig_in = 1'b0;
    rst_a_n = 1'b0;
    repeat (3) tick;
    rst_a_n = 1'b1;
    repeat (2) tick;
  endtask

  task automatic reset_b;
    ifb.sig_in = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) tick;
    rst_b_n = 1'b1;
    repeat (2) tick;
  endtask

  task automatic test_reset;
    ifa.sig_in = 1'b0; ifb.sig_in = 1'b0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) tick;
    checks++; if (ifa.period_out !== 28'd0) begin errors++; $display("FAIL reset_period got %0d required 0", ifa.period_out); end
    checks++; if (ifa.high_out !== 28'd0) begin errors++; $display("FAIL reset_high got %0d required 0", ifa.high_out); end
    checks++; if (ifa.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", ifa.valid); end
    checks++; if (ifa.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b required 0", ifa.timeout); end
    checks++; if (ifa.measuring !== 1'b0) begin errors++; $display("FAIL reset_measuring got %b required 0", ifa.measuring); end
    checks++; if (ifb.period_out !== 28'd0 || ifb.valid !== 1'b0 || ifb.timeout !== 1'b0)
      begin errors++; $display("FAIL reset_b got p=%0d v=%b t=%b required 0/0/0", ifb.period_out, ifb.valid, ifb.timeout); end
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    repeat (4) tick;
    checks++; if (ifa.measuring !== 1'b0 || ifa.valid !== 1'b0)
      begin errors++; $display("FAIL idle_after_release got m=%b v=%b required 0/0", ifa.measuring, ifa.valid); end
  endtask

  // Period 10, high 4: the first rise only starts measuring, each later rise reports.
  task automatic test_square;
    int w0;
    reset_a;
    clear_obs;
    w0 = cyc;
    wave_a(10, 4, 6);
    repeat (5) tick;
    for (int p = 1; p <= 5; p++) exp_q.push_back(28'd10);
    checks++; if (pa_q.size() !== 5) begin errors++; $display("FAIL square_count got %0d required 5", pa_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < pa_q.size()) begin
        checks++; if (pa_q[i] !== exp_q[i]) begin errors++; $display("FAIL square_period[%0d] got %0d required %0d", i, pa_q[i], exp_q[i]); end
        checks++; if (ha_q[i] !== (DUTY ? 28'd4 : 28'd0)) begin errors++; $display("FAIL square_high[%0d] got %0d required %0d", i, ha_q[i], DUTY ? 4 : 0); end
        // Pin rise driven during cycle k is reported during cycle k+3 (the 4th cycle).
        checks++; if (ta_q[i] !== w0 + 10 * (i + 1) + 3) begin errors++; $display("FAIL square_time[%0d] got %0d required %0d", i, ta_q[i], w0 + 10 * (i + 1) + 3); end
      end
    end
    checks++; if (ifa.timeout !== 1'b0) begin errors++; $display("FAIL square_timeout got %b required 0", ifa.timeout); end
    checks++; if (ifa.measuring !== 1'b1) begin errors++; $display("FAIL square_measuring got %b required 1", ifa.measuring); end
    checks++; if (dbl_a !== 1'b0) begin errors++; $display("FAIL square_valid_twice got %b required 0", dbl_a); end
  endtask

  task automatic test_timeout;
    int n;
    reset_a;
    clear_obs;
    wave_a(20, 7, 3);
    n = 0;
    while (ifa.timeout !== 1'b1 && n < 1200) begin
      tick;
      n++;
    end
    checks++; if (cyc !== last_rise_a + 1003) begin errors++; $display("FAIL timeout_time got %0d required %0d", cyc, last_rise_a + 1003); end
    checks++; if (ifa.timeout !== 1'b1) begin errors++; $display("FAIL timeout_level got %b required 1", ifa.timeout); end
    checks++; if (ifa.period_out !== 28'd0 || ifa.high_out !== 28'd0)
      begin errors++; $display("FAIL timeout_clear got p=%0d h=%0d required 0/0", ifa.period_out, ifa.high_out); end
    checks++; if (ifa.measuring !== 1'b0) begin errors++; $display("FAIL timeout_measuring got %b required 0", ifa.measuring); end
    checks++; if (pa_q.size() !== 2) begin errors++; $display("FAIL timeout_valids got %0d required 2", pa_q.size()); end
    if (pa_q.size() > 0) begin
      checks++; if (pa_q[0] !== 28'd20) begin errors++; $display("FAIL timeout_pre_period got %0d required 20", pa_q[0]); end
    end
    clear_obs;
    wave_a(20, 7, 1);
    checks++; if (ifa.timeout !== 1'b1 || ifa.measuring !== 1'b1 || pa_q.size() !== 0)
      begin errors++; $display("FAIL restart_first_rise got t=%b m=%b n=%0d required 1/1/0", ifa.timeout, ifa.measuring, pa_q.size()); end
    wave_a(20, 7, 2);
    checks++; if (ifa.timeout !== 1'b0) begin errors++; $display("FAIL restart_timeout got %b required 0", ifa.timeout); end
    checks++; if (pa_q.size() !== 2) begin errors++; $display("FAIL restart_valids got %0d required 2", pa_q.size()); end
    if (pa_q.size() > 0) begin
      checks++; if (pa_q[0] !== 28'd20 || ha_q[0] !== (DUTY ? 28'd7 : 28'd0))
        begin errors++; $display("FAIL restart_result got %0d/%0d required 20/%0d", pa_q[0], ha_q[0], DUTY ? 7 : 0); end
    end
  endtask

  // TIMEOUT=50: period 50 lands the rise on cnt==50 and must report; period 51 never reports.
  task automatic test_coincide;
    reset_b;
    clear_obs;
    wave_b(50, 25, 4);
    checks++; if (pb_q.size() !== 3) begin errors++; $display("FAIL coincide_count got %0d required 3", pb_q.size()); end
    for (int i = 0; i < pb_q.size(); i++) begin
      checks++; if (pb_q[i] !== 28'd50) begin errors++; $display("FAIL coincide_period[%0d] got %0d required 50", i, pb_q[i]); end
    end
    checks++; if (ifb.timeout !== 1'b0) begin errors++; $display("FAIL coincide_timeout got %b required 0", ifb.timeout); end
    reset_b;
    clear_obs;
    wave_b(51, 25, 4);
    checks++; if (pb_q.size() !== 0) begin errors++; $display("FAIL over_limit_count got %0d required 0", pb_q.size()); end
    checks++; if (ifb.timeout !== 1'b1) begin errors++; $display("FAIL over_limit_timeout got %b required 1", ifb.timeout); end
  endtask

  task automatic test_reset_mid;
    int w0;
    reset_a;
    clear_obs;
    wave_a(10, 4, 3);
    ifa.sig_in = 1'b1;
    tick; tick;
    checks++; if (ifa.period_out !== 28'd10) begin errors++; $display("FAIL mid_pre_period got %0d required 10", ifa.period_out); end
    #2 rst_a_n = 1'b0;
    #1;
    checks++; if (ifa.period_out !== 28'd0 || ifa.high_out !== 28'd0 || ifa.measuring !== 1'b0 || ifa.timeout !== 1'b0 || ifa.valid !== 1'b0)
      begin errors++; $display("FAIL mid_async_clear got p=%0d h=%0d m=%b t=%b v=%b required all 0",
                               ifa.period_out, ifa.high_out, ifa.measuring, ifa.timeout, ifa.valid); end
    ifa.sig_in = 1'b0;
    tick; tick;
    rst_a_n = 1'b1;
    tick;
    clear_obs;
    w0 = cyc;
    wave_a(12, 5, 3);
    checks++; if (pa_q.size() !== 2) begin errors++; $display("FAIL mid_valids got %0d required 2", pa_q.size()); end
    if (pa_q.size() > 0) begin
      checks++; if (pa_q[0] !== 28'd12 || ha_q[0] !== (DUTY ? 28'd5 : 28'd0))
        begin errors++; $display("FAIL mid_result got %0d/%0d required 12/%0d", pa_q[0], ha_q[0], DUTY ? 5 : 0); end
      checks++; if (ta_q[0] !== w0 + 15) begin errors++; $display("FAIL mid_first_time got %0d required %0d", ta_q[0], w0 + 15); end
    end
  endtask

  // sig_in high through release: the release cycle acts as a pin rise with high 3, low 5.
  task automatic test_high_at_reset;
    int w0;
    ifa.sig_in = 1'b1;
    rst_a_n = 1'b0;
    repeat (3) tick;
    checks++; if (ifa.measuring !== 1'b0 || ifa.valid !== 1'b0)
      begin errors++; $display("FAIL high_reset got m=%b v=%b required 0/0", ifa.measuring, ifa.valid); end
    rst_a_n = 1'b1;
    clear_obs;
    repeat (3) tick;
    ifa.sig_in = 1'b0;
    repeat (5) tick;
    checks++; if (ifa.measuring !== 1'b1 || pa_q.size() !== 0)
      begin errors++; $display("FAIL high_first_rise got m=%b n=%0d required 1/0", ifa.measuring, pa_q.size()); end
    w0 = cyc;
    wave_a(8, 3, 3);
    repeat (5) tick;
    checks++; if (pa_q.size() !== 3) begin errors++; $display("FAIL high_count got %0d required 3", pa_q.size()); end
    for (int i = 0; i < pa_q.size(); i++) begin
      checks++; if (pa_q[i] !== 28'd8 || ha_q[i] !== (DUTY ? 28'd3 : 28'd0))
        begin errors++; $display("FAIL high_result[%0d] got %0d/%0d required 8/%0d", i, pa_q[i], ha_q[i], DUTY ? 3 : 0); end
      checks++; if (ta_q[i] !== w0 + 8 * i + 3) begin errors++; $display("FAIL high_time[%0d] got %0d required %0d", i, ta_q[i], w0 + 8 * i + 3); end
    end
  endtask

  initial begin
    test_reset;
    test_square;
    test_timeout;
    test_coincide;
    test_reset_mid;
    test_high_at_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
